// File: rtl/act_requant.sv
// rtl/act_requant.sv - bias/shift/ReLU/saturate requantizer between systolic array and pooling
//
// Purpose:
//   Converts one frame of signed accumulator samples into signed DATA_WIDTH
//   samples. Each accepted sample goes through a two-stage pipeline.
//   Stage 1 computes (acc + bias) >>> shift. Stage 2 applies optional ReLU
//   and saturation. A four-state FSM (IDLE/RUN/DRAIN/DONE) counts inputs and
//   outputs against the latched frame length.
//
// Build option:
//   ACT_ROUND_EN - when defined, add 2^(shift-1) before the shift (round half up);
//                  when undefined, the shift truncates toward negative infinity.
//
// Ports:
//   clk        in   1           clock, rising edge
//   nrst       in   1           asynchronous active-low reset
//   start      in   1           begin a frame (sampled only in IDLE)
//   cfg_len    in   CNT_WIDTH   elements per frame
//   cfg_bias   in   ACC_WIDTH   signed bias
//   cfg_shift  in   5           arithmetic right-shift amount
//   cfg_relu   in   1           1 = apply ReLU
//   acc_valid  in   1           accumulator sample valid
//   acc_data   in   ACC_WIDTH   signed accumulator sample
//   acc_ready  out  1           accumulator sample accepted on valid & ready
//   out_valid  out  1           output sample valid
//   out_data   out  DATA_WIDTH  signed requantized sample
//   out_ready  in   1           downstream accepts the sample
//   busy       out  1           high outside IDLE
//   act_done   out  1           one-cycle pulse at frame completion

module act_requant #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  cfg_len,
    input  logic [ACC_WIDTH-1:0]  cfg_bias,
    input  logic [4:0]            cfg_shift,
    input  logic                  cfg_relu,
    input  logic                  acc_valid,
    input  logic [ACC_WIDTH-1:0]  acc_data,
    output logic                  acc_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  act_done
);

    // Two guard bits: one for the bias add, one for the rounding addend,
    // so no intermediate value can wrap.
    localparam int SW = ACC_WIDTH + 2;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   len_q;
    logic [ACC_WIDTH-1:0]   bias_q;
    logic [4:0]             shift_q;
    logic                   relu_q;
    logic [CNT_WIDTH-1:0]   in_cnt;
    logic [CNT_WIDTH-1:0]   out_cnt;

    logic                   s1_valid;
    logic signed [SW-1:0]   s1_data;

    logic                   out_fire;
    logic                   out_free;
    logic                   s1_free;
    logic                   in_fire;

    logic signed [SW-1:0]   sum_ext;
    logic signed [SW-1:0]   s_next;
    logic signed [SW-1:0]   relu_val;
    logic [DATA_WIDTH-1:0]  sat_data;

    // Handshake chain: the output register frees when empty or being
    // consumed, stage 1 frees when empty or able to move forward. A stall at
    // out_ready therefore reaches acc_ready in the same cycle.
    always_comb begin
        out_fire  = out_valid && out_ready;
        out_free  = !out_valid || out_ready;
        s1_free   = !s1_valid || out_free;
        acc_ready = (state == RUN) && (in_cnt < len_q) && s1_free;
        in_fire   = acc_valid && acc_ready;
    end

    // Stage 1 arithmetic: sign-extend both operands before adding.
    always_comb begin
        sum_ext = {{2{acc_data[ACC_WIDTH-1]}}, acc_data}
                + {{2{bias_q[ACC_WIDTH-1]}}, bias_q};
`ifdef ACT_ROUND_EN
        if (shift_q != 5'd0) begin
            sum_ext = sum_ext + (SW'(1) << (shift_q - 5'd1));
        end
`endif
        s_next = sum_ext >>> shift_q;
    end

    // Stage 2 arithmetic: ReLU on the sign bit, then clamp to DATA_WIDTH.
    always_comb begin
        relu_val = (relu_q && s1_data[SW-1]) ? '0 : s1_data;
        if (relu_val > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (relu_val < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_data = relu_val[DATA_WIDTH-1:0];
        end
    end

    // Datapath pipeline registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (s1_free) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    s1_data <= s_next;
                end
            end
            if (out_free) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= sat_data;
                end
            end
        end
    end

    // Control FSM, counters and latched configuration.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            len_q    <= '0;
            bias_q   <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            busy     <= 1'b0;
            act_done <= 1'b0;
        end else begin
            // Output handshakes are counted in RUN as well as DRAIN, since
            // early samples leave the pipeline while later ones still arrive.
            if (out_fire) begin
                out_cnt <= out_cnt + CNT_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= cfg_len;
                        bias_q  <= cfg_bias;
                        shift_q <= cfg_shift;
                        relu_q  <= cfg_relu;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        busy    <= 1'b1;
                        if (cfg_len == '0) begin
                            state    <= DONE;
                            act_done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (in_fire) begin
                        in_cnt <= in_cnt + CNT_WIDTH'(1);
                        if ((in_cnt + CNT_WIDTH'(1)) == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (out_fire && ((out_cnt + CNT_WIDTH'(1)) == len_q)) begin
                        state    <= DONE;
                        act_done <= 1'b1;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    act_done <= 1'b0;
                    busy     <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    act_done <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_act_requant.sv
// tb/tb_act_requant.sv - scoreboard testbench for act_requant

module tb_act_requant;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [15:0] cfg_len;
    logic [23:0] cfg_bias;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic        acc_valid;
    logic [23:0] acc_data;
    logic        acc_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic        act_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         lat_q[$];
    bit         lat_check = 0;
    bit         stall_prev = 0;
    logic [7:0] prev_data = '0;

    act_requant #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_bias  (cfg_bias),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .acc_valid (acc_valid),
        .acc_data  (acc_data),
        .acc_ready (acc_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .act_done  (act_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of the requantizer arithmetic.
    function automatic logic [7:0] model(input longint a, input longint b, input int sh, input bit relu);
        longint v;
        logic [63:0] r;
        v = a + b;
`ifdef ACT_ROUND_EN
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        r = v;
        return r[7:0];
    endfunction

    // Output monitor: pops the scoreboard on each handshake and checks that
    // a stalled output holds its value.
    always @(negedge clk) begin
        if (!nrst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: out_valid=%0b out_data=%0d, required 1 / %0d",
                             out_valid, $signed(out_data), $signed(prev_data));
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: out_data=%0d with empty scoreboard", $signed(out_data));
                end else begin
                    logic [7:0] e;
                    int ac;
                    e  = exp_q.pop_front();
                    ac = lat_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL out_data: got %0d, required %0d", $signed(out_data), $signed(e));
                    end
                    if (lat_check) begin
                        checks++;
                        if (cyc - ac != 2) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, required 2", cyc - ac);
                        end
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic start_frame(input int len, input int bias, input int sh, input bit relu);
        cfg_len   = len[15:0];
        cfg_bias  = bias[23:0];
        cfg_shift = sh[4:0];
        cfg_relu  = relu;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        // Scramble the live configuration; the frame must use the latched copy.
        cfg_len   = 16'd7;
        cfg_bias  = 24'h5A5A5A;
        cfg_shift = 5'd9;
        cfg_relu  = ~relu;
    endtask

    task automatic feed(input int x, input logic [7:0] e);
        int n = 0;
        bit accepted = 0;
        acc_valid = 1'b1;
        acc_data  = x[23:0];
        while (!accepted && n < 200) begin
            @(negedge clk);
            if (acc_ready) begin
                exp_q.push_back(e);
                lat_q.push_back(cyc);
                accepted = 1;
            end
            n++;
            @(posedge clk); #1;
        end
        acc_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: sample %0d not accepted within 200 cycles", x);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 500) begin
            @(negedge clk);
            if (act_done) seen = 1;
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done: act_done=0 after 500 cycles, required 1", name);
        end else begin
            @(negedge clk);
            checks++;
            if (act_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_done_pulse: act_done=%0b busy=%0b, required 0/0", name, act_done, busy);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d outputs missing, required 0", name, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || acc_ready !== 1'b0 || busy !== 1'b0 || act_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b data=%0d ready=%0b busy=%0b done=%0b, required all 0",
                     out_valid, out_data, acc_ready, busy, act_done);
        end
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        lat_check = 1;
        start_frame(3, 0, 2, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%0b, required 1", busy);
        end
        feed(300, 8'd75);
        feed(-40, 8'hF6);
        feed(1000, 8'd127);
        wait_done("basic");
        lat_check = 0;
    endtask

    task automatic test_rounding();
        start_frame(1, 0, 2, 0);
`ifdef ACT_ROUND_EN
        feed(302, 8'd76);
`else
        feed(302, 8'd75);
`endif
        wait_done("rounding");
    endtask

    task automatic test_relu_bias();
        start_frame(1, -100, 0, 1);
        feed(60, 8'd0);
        wait_done("relu");
        start_frame(1, 0, 0, 0);
        feed(-500, 8'h80);
        wait_done("sat_neg");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start_frame(4, 0, 2, 0);
        fork
            begin
                feed(100, 8'd25);
                feed(200, 8'd50);
                feed(-300, 8'hB5);
                feed(400, 8'd100);
            end
            begin
                repeat (4) @(negedge clk);
                checks++;
                if (acc_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_full: acc_ready=%0b out_valid=%0b, required 0/1", acc_ready, out_valid);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done("backpressure");
    endtask

    task automatic test_empty();
        start_frame(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (act_done !== 1'b1) begin
            errors++;
            $display("FAIL empty_done: act_done=%0b, required 1", act_done);
        end
        @(negedge clk);
        checks++;
        if (act_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_pulse: act_done=%0b busy=%0b, required 0/0", act_done, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        start_frame(5, 0, 2, 0);
        feed(300, 8'd75);
        feed(-40, 8'hF6);
        nrst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || acc_ready !== 1'b0 || busy !== 1'b0 || act_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%0b data=%0d ready=%0b busy=%0b done=%0b, required all 0",
                     out_valid, out_data, acc_ready, busy, act_done);
        end
        exp_q.delete();
        lat_q.delete();
        @(posedge clk); #1;
        nrst = 1'b1;
        acc_valid = 1'b1;
        acc_data  = 24'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || acc_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: busy=%0b acc_ready=%0b out_valid=%0b, required 0/0/0",
                     busy, acc_ready, out_valid);
        end
        acc_valid = 1'b0;
        test_basic();
    endtask

    task automatic test_back_to_back();
        int bias;
        int sh;
        bit relu;
        bit feed_done = 0;
        bias = int'($urandom) >>> 8;
        sh   = $urandom_range(0, 12);
        relu = 1'($urandom_range(0, 1));
        start_frame(20, bias, sh, relu);
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    int x;
                    if (i == 0)      x = 8388607;
                    else if (i == 1) x = -8388608;
                    else             x = int'($urandom) >>> 8;
                    feed(x, model(x, bias, sh, relu));
                end
                feed_done = 1;
            end
            begin
                while (!feed_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_done("back_to_back");
    endtask

    initial begin
        start     = 1'b0;
        cfg_len   = '0;
        cfg_bias  = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        acc_valid = 1'b0;
        acc_data  = '0;
        out_ready = 1'b1;
        nrst      = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_rounding();
        test_relu_bias();
        test_backpressure();
        test_empty();
        test_reset_midframe();
        for (int k = 0; k < 3; k++) test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/act_requant.md
ACT_REQUANT -- requirements
Module: act_requant

Interface
REQ-001 The module SHALL expose parameter DATA_WIDTH, default 8, giving the signed output sample width fed to pooling.
REQ-002 The module SHALL expose parameter ACC_WIDTH, default 24, giving the signed systolic-array accumulator width.
REQ-003 The module SHALL expose parameter CNT_WIDTH, default 16, giving the frame element counter width.
REQ-004 The module SHALL have these ports, each listed as name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- cfg_len  in  CNT_WIDTH  number of elements in the frame.
- cfg_bias  in  ACC_WIDTH  signed bias added to each accumulator value.
- cfg_shift  in  5  arithmetic right-shift amount, 0..ACC_WIDTH-1.
- cfg_relu  in  1  1 = apply ReLU.
- acc_valid  in  1  accumulator sample valid.
- acc_data  in  ACC_WIDTH  signed accumulator sample.
- acc_ready  out  1  sample accepted when acc_valid and acc_ready are both high.
- out_valid  out  1  output sample valid toward pooling.
- out_data  out  DATA_WIDTH  signed requantized sample.
- out_ready  in  1  pooling accepts the sample.
- busy  out  1  high in every state except IDLE.
- act_done  out  1  one-cycle pulse at frame completion.

Function
REQ-005 The FSM SHALL have four states, IDLE, RUN, DRAIN and DONE, with IDLE as the reset state.
REQ-006 In IDLE, start=1 SHALL latch all cfg_* inputs, clear in_cnt and out_cnt, and go to RUN, or go to DONE if cfg_len=0.
REQ-007 start SHALL be ignored outside IDLE, and the latched configuration SHALL stay constant until the next frame.
REQ-008 acc_ready SHALL be high only in RUN, with in_cnt<len and the pipeline able to advance.
REQ-009 in_cnt SHALL increment on each accepted sample, and the FSM SHALL go RUN->DRAIN in the cycle the len-th sample is accepted.
REQ-010 Stage 1 SHALL register s = acc_data + bias, computed in ACC_WIDTH+1 signed bits with no overflow, then arithmetically right-shifted by shift.
REQ-011 Stage 2 SHALL apply ReLU when enabled (negative values become 0), saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], and register the result to out_data/out_valid.
REQ-012 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held high, with throughput of 1 sample per cycle.
REQ-013 While out_valid=1 and out_ready=0, out_data SHALL hold stable, no sample SHALL be dropped or duplicated, and the stall SHALL propagate back to acc_ready.
REQ-014 out_cnt SHALL increment on each out_valid&&out_ready, and the FSM SHALL go DRAIN->DONE when out_cnt reaches len.
REQ-015 DONE SHALL last exactly one cycle, drive act_done=1, and return to IDLE.
REQ-016 A simultaneous input acceptance and output handshake SHALL both take effect in the same cycle.

Reset
REQ-017 nrst low SHALL immediately force state=IDLE, counters=0, pipeline valids=0, out_valid=0, out_data=0, acc_ready=0, busy=0 and act_done=0, including mid-frame.
REQ-018 After reset is released, the module SHALL need a new start; in-flight samples SHALL be discarded.

Configuration
REQ-019 Macro ACT_ROUND_EN defined SHALL add 2^(shift-1) to s before shifting when shift>0 (round half up).
REQ-020 ACT_ROUND_EN undefined SHALL truncate toward negative infinity with no rounding adder; all other behaviour is identical.

Verification
REQ-021 Scenario "basic": len=3, bias=0, shift=2, relu=0, samples 300, -40, 1000 -> outputs 75, -10, 127 in order, then one act_done pulse.
REQ-022 Scenario "rounding": sample 302, shift=2 -> output 76 with ACT_ROUND_EN, 75 without it.
REQ-023 Scenario "relu/bias": relu=1, bias=-100, sample 60, shift=0 -> output 0; sample -500 with relu=0 -> -128.
REQ-024 Scenario "backpressure": out_ready=0 for 5 cycles while 4 samples are offered -> out_data stable, acc_ready low once the pipeline is full, all 4 samples delivered in order after release.
REQ-025 Scenario "empty": len=0, start -> act_done one cycle later, out_valid never asserted.
REQ-026 Scenario "reset mid-frame": nrst pulsed after 2 of 5 samples -> outputs cleared at once, IDLE, and a new frame after start behaves as in the "basic" scenario.
